// File: rtl/custom_axi_result_fifo_pkg.sv
// Shared types and constants for the custom AXI result FIFO.
package custom_axi_result_fifo_pkg;

    typedef enum logic [1:0] {FIFO_EMPTY, FIFO_ACTIVE, FIFO_FULL} fifo_state_e;

    localparam logic [1:0] RES_EN_VALID = 2'b01;

endpackage

// File: rtl/custom_axi_result_fifo_mem.sv
// DEPTH x DATA_WIDTH storage for the result FIFO: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module custom_axi_result_fifo_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                         clk_i,
    input  logic                         we_i,
    input  logic [$clog2(DEPTH)-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0]        rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/custom_axi_result_fifo.sv
// First-word-fall-through buffer for results emitted by the custom AXI core.
// Optional push/drop statistics counters: define CUSTOM_AXI_RESULT_FIFO_STATS_EN.
module custom_axi_result_fifo
    import custom_axi_result_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [DATA_WIDTH:0]        res_i,
    input  logic [1:0]                 res_en_i,
    input  logic                       clear_i,
    output logic [DATA_WIDTH-1:0]      rd_data_o,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output fifo_state_e                state_o,
    output logic                       overflow_o,
    output logic                       proto_err_o
`ifdef CUSTOM_AXI_RESULT_FIFO_STATS_EN
    ,
    output logic [15:0]                push_cnt_o,
    output logic [15:0]                drop_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    fifo_state_e           state_q, state_d;
    logic                  overflow_q, overflow_d;
    logic                  proto_err_q, proto_err_d;
    logic                  push_req, bad_code, full, pop, push, drop;
    logic [DATA_WIDTH-1:0] mem_rdata;

    always_comb begin
        full     = (count_q == FULL_CNT);
        push_req = (res_en_i == RES_EN_VALID) && res_i[0];
        bad_code = ((res_en_i == RES_EN_VALID) && !res_i[0]) || res_en_i[1];
        pop      = (count_q != '0) && rd_ready_i;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push     = push_req && (!full || pop) && !clear_i;
        drop     = push_req && full && !pop && !clear_i;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        proto_err_d = proto_err_q;

        if (clear_i) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            proto_err_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (drop) begin
                overflow_d = 1'b1;
            end
            if (bad_code) begin
                proto_err_d = 1'b1;
            end
        end

        if (count_d == '0) begin
            state_d = FIFO_EMPTY;
        end else if (count_d == FULL_CNT) begin
            state_d = FIFO_FULL;
        end else begin
            state_d = FIFO_ACTIVE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= FIFO_EMPTY;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
        end
    end

    custom_axi_result_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (res_i[DATA_WIDTH:1]),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    assign rd_valid_o  = (count_q != '0);
    assign rd_data_o   = rd_valid_o ? mem_rdata : '0;
    assign count_o     = count_q;
    assign state_o     = state_q;
    assign overflow_o  = overflow_q;
    assign proto_err_o = proto_err_q;

`ifdef CUSTOM_AXI_RESULT_FIFO_STATS_EN
    logic [15:0] push_cnt_q, push_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        push_cnt_d = push_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_i) begin
            push_cnt_d = '0;
            drop_cnt_d = '0;
        end else begin
            if (push && (push_cnt_q != '1)) begin
                push_cnt_d = push_cnt_q + 16'd1;
            end
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            push_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            push_cnt_q <= push_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign push_cnt_o = push_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: doc/custom_axi_result_fifo.md
# custom_axi_result_fifo

Downstream buffering stage for the custom AXI IP core. It captures each completed result the core emits on its `{data, valid}` output bus, qualified by its enable bus. Captured results are queued in a small first-word-fall-through FIFO and presented to the register/AXI-Lite read side through a valid/ready handshake. Results that arrive while the FIFO is full are dropped and flagged, and illegal enable codes from the core are flagged as protocol errors.

## Interface
- `DATA_WIDTH`, 32, width of result payload.
- `DEPTH`, 4, number of FIFO entries; power of two, ≥ 2.
- `clk_i`  input  1  clock; all logic on rising edge.
- `rst_ni`  input  1  reset, asynchronous, active-low.
- `res_i`  input  DATA_WIDTH+1  result from core: `[DATA_WIDTH:1]` data, `[0]` valid marker.
- `res_en_i`  input  2  core enable code: 2'b01 = result present, 2'b00 = idle, 2'b10/2'b11 illegal.
- `clear_i`  input  1  synchronous flush; also clears the sticky flags.
- `rd_data_o`  output  DATA_WIDTH  head-of-FIFO data.
- `rd_valid_o`  output  1  head entry valid.
- `rd_ready_i`  input  1  consumer accepts the head when high together with `rd_valid_o`.
- `count_o`  output  $clog2(DEPTH)+1  current occupancy.
- `state_o`  output  fifo_state_e  EMPTY / ACTIVE / FULL.
- `overflow_o`  output  1  sticky; a result was dropped because the FIFO was full.
- `proto_err_o`  output  1  sticky; an illegal enable code or marker was seen.

## Operation
- Push condition: `res_en_i == 2'b01 && res_i[0]`. On a push, store `res_i[DATA_WIDTH:1]` at the write pointer.
- Protocol error conditions, each of which sets `proto_err_o` and causes no push:
  - `res_en_i == 2'b01` with `res_i[0] == 0`;
  - `res_en_i` equal to 2'b10 or 2'b11.
- Pop condition: `rd_valid_o && rd_ready_i`. The read pointer advances.
- Full plus push without pop: the result is dropped, `overflow_o` is set, and the contents are unchanged.
- Full plus push with pop in the same cycle: both happen, and occupancy stays at DEPTH.
- Empty plus push: no pop is possible that cycle, because `rd_valid_o` is low.
- `clear_i` has priority over push and pop:
  - the pointers and count go to 0;
  - both sticky flags are cleared;
  - a same-cycle push is discarded and is neither an overflow nor a protocol error.
- State machine, updated on the registered count:
  - EMPTY→ACTIVE on a push;
  - ACTIVE→FULL when the count reaches DEPTH;
  - FULL→ACTIVE on a pop without a push;
  - ACTIVE→EMPTY when the count reaches 0;
  - any state→EMPTY on `clear_i`.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. The count is kept separately, one bit wider than the pointers.
- Reset mid-operation: all contents are abandoned immediately (asynchronous reset); no partial output is produced.

## Timing
- Reset values:
  - `rd_data_o` = 0, `rd_valid_o` = 0, `count_o` = 0;
  - `state_o` = EMPTY, `overflow_o` = 0, `proto_err_o` = 0;
  - pointers = 0. Memory contents are don't-care, but `rd_data_o` is forced to 0 while the FIFO is empty.
- Write latency: a push on edge N gives `rd_valid_o` = 1 and the data on `rd_data_o` after edge N (first-word-fall-through, 1-cycle latency).
- Pop: the next entry, if any, appears on `rd_data_o` in the cycle after the accepting edge. Back-to-back pops at 1 per cycle are supported.
- `rd_data_o` must hold stable while `rd_valid_o` is high and `rd_ready_i` is low.
- Sticky flags assert in the cycle after the offending edge and remain set until `clear_i` or reset.
- `count_o` and `state_o` are registered and reflect the pushes and pops of the previous edge.

## Configuration
- Macro: `CUSTOM_AXI_RESULT_FIFO_STATS_EN`.
- Defined: adds the following outputs, cleared by reset and by `clear_i`:
  - `push_cnt_o` [15:0]: counts accepted pushes;
  - `drop_cnt_o` [15:0]: counts overflow drops;
  - both counters saturate at 16'hFFFF.
- Undefined: neither port nor counter exists; everything else is identical.

## Structure
- Package `custom_axi_result_fifo_pkg` holds:
  - `typedef enum logic [1:0] {FIFO_EMPTY, FIFO_ACTIVE, FIFO_FULL} fifo_state_e`;
  - `localparam RES_EN_VALID = 2'b01`.
- The existing `custom_axi_ip_pkg` is untouched.
- One natural sub-module, `custom_axi_result_fifo_mem`: a DEPTH×DATA_WIDTH register array with one write port and an asynchronous read port. Pointers, count, flags and the FSM live in the top level.

## Test plan
- Reset, then push `res_i` = {32'h0000_0010, 1'b1} with `res_en_i` = 01 → next cycle `rd_valid_o` = 1, `rd_data_o` = 32'h10, `count_o` = 1, `state_o` = ACTIVE.
- Push 5 results 1..5 with `rd_ready_i` = 0 (DEPTH = 4) → `count_o` = 4, `state_o` = FULL, `overflow_o` = 1; draining yields 1, 2, 3, 4 and then `rd_valid_o` = 0.
- With FIFO full, push 9 and pop in the same cycle → `count_o` stays 4, `overflow_o` stays 0, and the final entry drained is 9.
- Drive `res_en_i` = 01 with `res_i[0]` = 0, then `res_en_i` = 11 → `proto_err_o` = 1, `count_o` unchanged.
- While 3 entries are queued and both flags are set, assert `clear_i` together with a valid push → next cycle `count_o` = 0, `state_o` = EMPTY, both flags = 0, and the pushed data is absent.
- Assert `rst_ni` low mid-drain with STATS_EN defined → all outputs return to reset values immediately, including `push_cnt_o` = 0 and `drop_cnt_o` = 0.
